// File: rtl/systolic_array_2x2.sv
// systolic_array_2x2
// Output-stationary 2x2 signed systolic array computing C = A x B from the
// skewed operand streams produced by the MMU feeder.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-high reset
//   clear            synchronous clear of accumulators, pipeline regs and step counter
//   a_data0/a_data1  A (weight) operands entering PE00 / PE10 from the left
//   b_data0/b_data1  B (input) operands entering PE00 / PE01 from the top
//   c00..c11         signed accumulators of PE00, PE01, PE10, PE11 (wrap, no saturation)
//   valid            high once all four accumulators hold a complete 2-term dot product
module systolic_array_2x2 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_data0,
  input  logic [DATA_W-1:0] a_data1,
  input  logic [DATA_W-1:0] b_data0,
  input  logic [DATA_W-1:0] b_data1,
  output logic [ACC_W-1:0]  c00,
  output logic [ACC_W-1:0]  c01,
  output logic [ACC_W-1:0]  c10,
  output logic [ACC_W-1:0]  c11,
  output logic              valid
);

  localparam int unsigned ProdW = 2 * DATA_W;

  // PE index: 0 = PE00, 1 = PE01, 2 = PE10, 3 = PE11
  logic signed [DATA_W-1:0] pe_a    [4];
  logic signed [DATA_W-1:0] pe_b    [4];
  logic signed [ProdW-1:0]  prod    [4];
  logic signed [DATA_W-1:0] a_reg_q [4];
  logic signed [DATA_W-1:0] b_reg_q [4];
  logic signed [ACC_W-1:0]  acc_q   [4];
  logic signed [ACC_W-1:0]  acc_d   [4];

  logic [2:0] step_q;
  logic [2:0] step_d;
  logic       valid_q;

  // Operand routing: A flows right along a row, B flows down a column.
  always_comb begin
    pe_a[0] = a_data0;
    pe_b[0] = b_data0;
    pe_a[1] = a_reg_q[0];
    pe_b[1] = b_data1;
    pe_a[2] = a_data1;
    pe_b[2] = b_reg_q[0];
    pe_a[3] = a_reg_q[2];
    pe_b[3] = b_reg_q[1];
  end

  // Full-width signed product, sign-extended into the accumulator width.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      prod[p]  = ProdW'(pe_a[p]) * ProdW'(pe_b[p]);
      acc_d[p] = acc_q[p] + ACC_W'(prod[p]);
    end
  end

  // Step counter saturates at 4; valid is the registered "reached 4" flag.
  always_comb begin
    step_d = (step_q == 3'd4) ? step_q : step_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        acc_q[p]   <= '0;
        a_reg_q[p] <= '0;
        b_reg_q[p] <= '0;
      end
      step_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      for (int p = 0; p < 4; p++) begin
        acc_q[p]   <= '0;
        a_reg_q[p] <= '0;
        b_reg_q[p] <= '0;
      end
      step_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        acc_q[p]   <= acc_d[p];
        a_reg_q[p] <= pe_a[p];
        b_reg_q[p] <= pe_b[p];
      end
      step_q  <= step_d;
      valid_q <= (step_d == 3'd4);
    end
  end

  assign c00   = acc_q[0];
  assign c01   = acc_q[1];
  assign c10   = acc_q[2];
  assign c11   = acc_q[3];
  assign valid = valid_q;

endmodule

// File: doc/systolic_array_2x2.md
# systolic_array_2x2

- Output-stationary 2x2 signed-int8 systolic array.
- Consumes the skewed operand streams and `clear` produced by the MMU feeder and computes C = A x B:
  - A is the weight matrix: row 0 = w0,w1; row 1 = w2,w3.
  - B is the input matrix: row 0 = in0,in1; row 1 = in2,in3.
- Holds the four 16-bit accumulators c00..c11, which the feeder reads back and saturates for the host.
- Adds a `valid` flag that marks when all four results are final.

## Interface
- DATA_W, 8, operand width (signed two's complement)
- ACC_W, 16, accumulator/result width (signed)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear of accumulators, pipeline registers and step counter
- a_data0  in  DATA_W  row-0 A operand, enters PE00 from the left
- a_data1  in  DATA_W  row-1 A operand, enters PE10 from the left
- b_data0  in  DATA_W  column-0 B operand, enters PE00 from the top
- b_data1  in  DATA_W  column-1 B operand, enters PE01 from the top
- c00, c01, c10, c11  out  ACC_W each  signed accumulators of PE00, PE01, PE10, PE11
- valid  out  1  high when all four accumulators hold a complete 2-term dot product

## Operation
- Four PEs. Each PE holds:
  - acc (ACC_W)
  - a_reg, a pass-right register (DATA_W)
  - b_reg, a pass-down register (DATA_W)
- Operand sources:
  - PE00: a_data0, b_data0
  - PE01: a = PE00.a_reg, b = b_data1
  - PE10: a = a_data1, b = PE00.b_reg
  - PE11: a = PE10.a_reg, b = PE01.b_reg
- Per edge with clear=0, each PE:
  - acc <= acc + sext(a)*sext(b)
  - a_reg <= a
  - b_reg <= b
- Arithmetic:
  - Operands are signed DATA_W.
  - The product is the full 2*DATA_W signed value, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation here. Saturation is the feeder's job.
- clear=1 at an edge zeroes every acc, a_reg, b_reg and the step counter; no accumulation happens on that edge. clear has priority over data.
- Step counter (3 bits):
  - 0 on clear; +1 per edge with clear=0, saturating at 4.
  - valid is registered and goes high on the edge the counter reaches 4.
  - valid stays high until the next clear or reset.
- After valid, the array keeps accumulating whatever is presented. The feeder drives zeros, so the results hold.
- c00..c11 are the acc registers directly (no output mux, no extra latency).

## Timing
- Reset values: c00..c11 = 0, valid = 0, all a_reg/b_reg = 0, step = 0.
- Edge numbering:
  - E1 is the first edge sampling clear=0. The feeder drops clear and drives a_data0=w0, b_data0=in0 on the same edge E0.
- E1: c00 += w0*in0.
- E2: c00 += w1*in2 (final); c01 += w0*in1; c10 += w2*in0.
- E3: c01 += w1*in3 (final); c10 += w3*in2 (final); c11 += w2*in1.
- E4: c11 += w3*in3 (final); step = 4, valid = 1 visible after E4.
- Boundary conditions:
  - **clear mid-operation:** all state is zero after that edge and the sequence restarts at the next clear=0 edge.
  - **rst mid-operation:** all state clears immediately, independent of clk.
  - **Accumulator overflow:** (-128)*(-128) + (-128)*(-128) = 32768 wraps to -32768 (0x8000).
  - **clear held high:** outputs stay 0 and valid stays 0.

## Test plan
- **Reset/clear:** assert rst mid-run with non-zero accumulators -> c00..c11 = 0 and valid = 0 immediately; hold clear=1 for 3 edges -> c00..c11 remain 0 and valid remains 0.
- **Identity:** W = [[1,0],[0,1]], In = [[5,6],[7,8]], driven with the feeder skew -> after E4 c00=5, c01=6, c10=7, c11=8; valid rises exactly after E4, not E3.
- **Signed mix:** W = [[-3,2],[4,-1]], In = [[10,-20],[30,5]] -> c00=30, c01=70, c10=10, c11=-85; check intermediate c00=-30 after E1.
- **Wrap:** all weights and inputs = -128 (0x80) -> all four accumulators = 0x8000 (-32768) after E4; W all 127, In all 127 -> 32258 (0x7E02).
- **Mid-op clear:** start the identity run, assert clear at E2 -> all c and valid are 0 after that edge; re-run with W = [[2,0],[0,2]], In = [[1,2],[3,4]] -> 2,4,6,8 with valid after the new E4.
- **Back-to-back runs:** two consecutive feeder runs separated by one clear edge -> second results are independent of the first (no residue in a_reg/b_reg).
